// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage.
//   mem_state_t  : access FSM states (IDLE, ACCESS)
//   memwb_t      : contents of the MEM/WB pipeline register
//   MEMWB_BUBBLE : MEM/WB value for an empty slot (controls and fields cleared)
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic        MemToReg;
    logic        RegWrite;
    logic [31:0] mem_data;
    logic [31:0] alu;
    logic [3:0]  RR3;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/segment_mem_wb.sv
// MEM/WB pipeline register, updated on the falling clock edge.
// Ports:
//   clk_i        : clock (falling edge active)
//   rst_i        : asynchronous active-high reset, clears all fields
//   bubble_i     : load an empty slot; mem_data keeps its previous value
//   load_data_i  : when not bubbling, also capture d_i.mem_data
//   d_i          : next MEM/WB contents
//   q_o          : registered MEM/WB contents
module segment_mem_wb
  import mem_stage_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   bubble_i,
  input  logic   load_data_i,
  input  memwb_t d_i,
  output memwb_t q_o
);

  memwb_t q_q;
  memwb_t q_d;

  always_comb begin
    q_d = q_q;
    if (bubble_i) begin
      q_d          = MEMWB_BUBBLE;
      q_d.mem_data = q_q.mem_data;
    end else begin
      q_d.MemToReg = d_i.MemToReg;
      q_d.RegWrite = d_i.RegWrite;
      q_d.alu      = d_i.alu;
      q_d.RR3      = d_i.RR3;
      if (load_data_i) begin
        q_d.mem_data = d_i.mem_data;
      end
    end
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues data-memory loads/stores over a req/ready handshake,
// stalls the upstream pipeline while an access is outstanding, aborts an
// access after TIMEOUT_CYCLES cycles, and holds the MEM/WB register.
// Ports:
//   clk, rst                    : falling-edge clock, async active-high reset
//   MemToReg_in .. RR3_in       : EX/MEM register outputs
//   dmem_req/we/addr/wdata      : data-memory request (held for whole access)
//   dmem_rdata, dmem_ready      : data-memory response
//   stall_out                   : freezes PC, IF/ID, ID/EX, EX/MEM
//   err_out                     : sticky fault (illegal access or timeout)
//   MemToReg_out .. RR3_out     : MEM/WB register outputs
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemToReg_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] RD3_in,
  input  logic [3:0]  RR3_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_out,
  output logic        err_out,
  output logic        MemToReg_out,
  output logic        RegWrite_out,
  output logic [31:0] mem_data_out,
  output logic [31:0] alu_out,
  output logic [3:0]  RR3_out
);

  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             err_q, err_d;

  logic   mem_op;
  logic   illegal;
  logic   timeout_hit;
  logic   wb_bubble;
  logic   wb_load_data;
  memwb_t wb_d;
  memwb_t wb_q;

  assign mem_op      = MemRead_in | MemWrite_in;
  assign illegal     = mem_op & ((MemRead_in & MemWrite_in) | (alu_in[1:0] != 2'b00));
  assign timeout_hit = (state_q == ACCESS) & ~dmem_ready & (cnt_q == CNT_LAST);

  // The stall drops in the completing/aborting cycle so EX/MEM advances on
  // the same edge MEM/WB captures the result. Gated by rst so every output
  // reads 0 while reset is held.
  assign stall_out = ~rst & mem_op & ~illegal &
                     ~((state_q == ACCESS) & (dmem_ready | timeout_hit));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    err_d        = err_q;
    wb_bubble    = 1'b0;
    wb_load_data = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (illegal) begin
          err_d     = 1'b1;
          wb_bubble = 1'b1;
        end else if (mem_op) begin
          addr_d    = alu_in;
          wdata_d   = RD3_in;
          we_d      = MemWrite_in;
          cnt_d     = '0;
          wb_bubble = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          wb_load_data = ~we_q;
          state_d      = IDLE;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          wb_bubble = 1'b1;
          state_d   = IDLE;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          wb_bubble = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign wb_d = '{MemToReg: MemToReg_in, RegWrite: RegWrite_in,
                  mem_data: dmem_rdata, alu: alu_in, RR3: RR3_in};

  segment_mem_wb u_mem_wb (
    .clk_i       (clk),
    .rst_i       (rst),
    .bubble_i    (wb_bubble),
    .load_data_i (wb_load_data),
    .d_i         (wb_d),
    .q_o         (wb_q)
  );

  assign dmem_req     = (state_q == ACCESS);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign err_out      = err_q;
  assign MemToReg_out = wb_q.MemToReg;
  assign RegWrite_out = wb_q.RegWrite;
  assign mem_data_out = wb_q.mem_data;
  assign alu_out      = wb_q.alu;
  assign RR3_out      = wb_q.RR3;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        MemToReg_in, MemRead_in, MemWrite_in, RegWrite_in;
  logic [31:0] alu_in, RD3_in;
  logic [3:0]  RR3_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        stall_out, err_out;
  logic        MemToReg_out, RegWrite_out;
  logic [31:0] mem_data_out, alu_out;
  logic [3:0]  RR3_out;

  int checks = 0;
  int failures = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .MemToReg_in(MemToReg_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .RegWrite_in(RegWrite_in),
    .alu_in(alu_in), .RD3_in(RD3_in), .RR3_in(RR3_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_out(stall_out), .err_out(err_out),
    .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out),
    .mem_data_out(mem_data_out), .alu_out(alu_out), .RR3_out(RR3_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, m2r, rw;
    logic [31:0] alu, rd3;
    logic [3:0]  rr3;
    int          wait_n;     // ACCESS cycles before ready; -1 = never
    logic        idle_rdy;   // drive ready high while still in IDLE
    logic [31:0] rdata;
    logic        e_m2r, e_rw;
    logic [31:0] e_alu;
    logic [3:0]  e_rr3;
    logic [31:0] e_mdata;
    logic        e_err;
    int          e_stall, e_req;
  } vec_t;

  vec_t tbl[13];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    MemToReg_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; RegWrite_in = 1'b0;
    alu_in = '0; RD3_in = '0; RR3_in = '0;
    dmem_ready = 1'b0; dmem_rdata = '0;
  endtask

  // Entered and left at falling edge + 1.
  task automatic run_op(input string tag, input vec_t v);
    int   stalls = 0;
    int   reqs = 0;
    int   cyc = 0;
    bit   done = 0;
    vec_t e;
    chk({tag, "_req_idle"}, 32'(dmem_req), 32'd0);
    MemToReg_in = v.m2r; MemRead_in = v.rd; MemWrite_in = v.wr; RegWrite_in = v.rw;
    alu_in = v.alu; RD3_in = v.rd3; RR3_in = v.rr3;
    sb.push_back(v);
    while (!done && cyc < 40) begin
      if (dmem_req) begin
        chk({tag, "_addr"}, dmem_addr, v.alu);
        chk({tag, "_we"}, 32'(dmem_we), 32'(v.wr));
        chk({tag, "_wdata"}, dmem_wdata, v.rd3);
        dmem_ready = (v.wait_n >= 0) && (reqs == v.wait_n);
        dmem_rdata = dmem_ready ? v.rdata : (32'h5A5A_0000 ^ 32'(reqs));
        reqs++;
      end else begin
        dmem_ready = v.idle_rdy;
        dmem_rdata = 32'hFFFF_0000;
      end
      #1;
      if (stall_out) stalls++;
      else done = 1;
      @(negedge clk); #1;
      cyc++;
    end
    if (!done) chk({tag, "_retire_budget"}, 32'(cyc), 32'd0);
    drive_idle();
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_MemToReg"}, 32'(MemToReg_out), 32'(e.e_m2r));
      chk({tag, "_RegWrite"}, 32'(RegWrite_out), 32'(e.e_rw));
      chk({tag, "_alu"}, alu_out, e.e_alu);
      chk({tag, "_RR3"}, 32'(RR3_out), 32'(e.e_rr3));
      chk({tag, "_mem_data"}, mem_data_out, e.e_mdata);
      chk({tag, "_err"}, 32'(err_out), 32'(e.e_err));
      chk({tag, "_stall_cycles"}, 32'(stalls), 32'(e.e_stall));
      chk({tag, "_req_cycles"}, 32'(reqs), 32'(e.e_req));
    end
  endtask

  initial begin
    vec_t rv;
    //            rd    wr    m2r   rw    alu            rd3            rr3   wt  irdy  rdata          em2r  erw   ealu           err3  emdata         eerr  stl req
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0055, 32'h0000_0000, 4'd3,  0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0055, 4'd3,  32'h0,         1'b0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1111, 4'd15, 0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 4'd15, 32'h0,         1'b0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_2222, 4'd5,  3, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0010, 4'd5,  32'hDEAD_BEEF, 1'b0, 4, 4};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h1234_5678, 4'd0,  0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0000_0020, 4'd0,  32'hDEAD_BEEF, 1'b0, 1, 1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_3333, 4'd7,  0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 32'h0000_0044, 4'd7,  32'hA5A5_0001, 1'b0, 1, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_4444, 4'd9,  3, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b1, 32'h0000_0080, 4'd9,  32'h0BAD_F00D, 1'b0, 4, 4};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_0000, 4'd2,  0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0000_1000, 4'd2,  32'h0BAD_F00D, 1'b0, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0022, 32'h0000_0000, 4'd4,  0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         4'd0,  32'h0BAD_F00D, 1'b1, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0030, 32'h0000_5555, 4'd6,  0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         4'd0,  32'h0BAD_F00D, 1'b1, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0077, 32'h0000_0000, 4'd1,  0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0077, 4'd1,  32'h0BAD_F00D, 1'b1, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'd6, -1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         4'd0,  32'h0BAD_F00D, 1'b1, 4, 4};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0099, 32'h0000_0000, 4'd8,  0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0099, 4'd8,  32'h0BAD_F00D, 1'b1, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0021, 32'h0000_6666, 4'd0,  0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         4'd0,  32'h0BAD_F00D, 1'b1, 0, 0};

    rst = 1'b1;
    drive_idle();
    #12;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_RegWrite", 32'(RegWrite_out), 32'd0);
    chk("rst_alu", alu_out, 32'd0);
    chk("rst_mem_data", mem_data_out, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("v%0d", i), tbl[i]);
    end

    // Reset asserted in the 2nd ACCESS cycle of a load that never completes.
    MemRead_in = 1'b1; MemToReg_in = 1'b1; RegWrite_in = 1'b1;
    alu_in = 32'h0000_0050; RR3_in = 4'd10;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("mid_req_before_rst", 32'(dmem_req), 32'd1);
    chk("mid_stall_before_rst", 32'(stall_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall_out), 32'd0);
    chk("mid_rst_err", 32'(err_out), 32'd0);
    chk("mid_rst_mem_data", mem_data_out, 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    drive_idle();

    rv = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0060, 32'h0, 4'd11, 0, 1'b0, 32'h600D_600D,
           1'b1, 1'b1, 32'h0000_0060, 4'd11, 32'h600D_600D, 1'b0, 1, 1};
    run_op("post_rst", rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
